program_loader: RTL

//  Boot-time byte-stream loader that sits directly upstream of the RISCuin core.

---
 rtl/program_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: parses A5|LEN|data|CSUM frames from a byte stream, writes 32-bit
// little-endian words into program memory and releases the core once verified.
module program_loader #(
  parameter int unsigned INSTR_ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  input  logic [7:0]                  s_data,
  output logic                        s_ready,
  output logic                        pgm,
  output logic                        mem_we,
  output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]                 mem_wdata,
  output logic                        core_rst,
  output logic                        done,
  output logic                        error
);
  localparam int unsigned W         = INSTR_ADDR_WIDTH;
  localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [32:0] MAX_WORDS = 33'(1) << W;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {SYNC, LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

  state_t              state_q;
  logic [15:0]         len_q;
  logic [W:0]          word_idx_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         word_q;
  logic [7:0]          xor_q;
  logic [IDLE_W-1:0]   idle_q;
  logic                s_ready_q, pgm_q, mem_we_q, core_rst_q, done_q, error_q;
  logic [W-1:0]        mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic        hs;
  logic        in_frame;
  logic [15:0] len_full;
  logic        last_word;

  assign hs        = s_valid && s_ready_q;
  assign in_frame  = (state_q == LEN0) || (state_q == LEN1) ||
                     (state_q == DATA) || (state_q == CSUM);
  assign len_full  = {s_data, len_q[7:0]};
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SYNC;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      xor_q       <= '0;
      idle_q      <= '0;
      s_ready_q   <= 1'b1;
      pgm_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (in_frame && !hs) idle_q <= idle_q + IDLE_W'(1);
      else                 idle_q <= '0;

      unique case (state_q)
        SYNC: if (hs && s_data == SYNC_BYTE) begin
          state_q <= LEN0;
          pgm_q   <= 1'b1;
        end
        LEN0: if (hs) begin
          len_q[7:0] <= s_data;
          state_q    <= LEN1;
        end
        LEN1: if (hs) begin
          len_q[15:8] <= s_data;
          word_idx_q  <= '0;
          byte_idx_q  <= '0;
          xor_q       <= '0;
          if (33'(len_full) > MAX_WORDS) begin
            state_q <= ERR;
            error_q <= 1'b1;
            pgm_q   <= 1'b0;
          end else if (len_full == 16'd0) begin
            state_q <= CSUM;
          end else begin
            state_q <= DATA;
          end
        end
        DATA: if (hs) begin
          xor_q      <= xor_q ^ s_data;
          byte_idx_q <= byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_q[7:0]   <= s_data;
            2'd1: word_q[15:8]  <= s_data;
            2'd2: word_q[23:16] <= s_data;
            default: begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_idx_q[W-1:0];
              mem_wdata_q <= {s_data, word_q};
              word_idx_q  <= word_idx_q + 1'b1;
              if (last_word) state_q <= CSUM;
            end
          endcase
        end
        CSUM: if (hs) begin
          pgm_q <= 1'b0;
          if (s_data == xor_q) begin
            state_q    <= RUN;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
            s_ready_q  <= 1'b0;
          end else begin
            state_q <= ERR;
            error_q <= 1'b1;
          end
        end
        RUN: ;
        ERR: if (hs && s_data == SYNC_BYTE) begin
          state_q <= LEN0;
          error_q <= 1'b0;
          pgm_q   <= 1'b1;
        end
        default: state_q <= SYNC;
      endcase

      // Timeout overrides the case above; it can only fire on a cycle without a handshake.
      if (in_frame && !hs && idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        state_q <= ERR;
        error_q <= 1'b1;
        pgm_q   <= 1'b0;
      end
    end
  end

  assign s_ready   = s_ready_q;
  assign pgm       = pgm_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign error     = error_q;
endmodule
